multi_tick_gen: RTL and testbench
=================================

Name: multi_tick_gen

Overview:
- Parametrised successor to the fixed 100 MHz -> 5 Hz divider.
- Generates N_CH independent tick strobes from the single system clock.
- Each channel has a runtime-loadable divisor, an enable, a one-cycle tick pulse output and a 50 % square output.
- Sits between the board clock and the slow control logic (servo update rate, SPI poll rate, LED blink), replacing per-function fixed dividers.

Parameters:
- N_CH, 2, number of independent channels (1..8).
- DIV_W, 25, width of the divisor and counter per channel.
- DEFAULT_DIV, 19999999, divisor loaded at reset into every channel (5 Hz at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- en  in  N_CH  per-channel count enable, level.
- load  in  N_CH  per-channel divisor load strobe, one cycle.
- div_in  in  N_CH*DIV_W  new divisors; channel k uses bits [k*DIV_W +: DIV_W].
- tick  out  N_CH  one-cycle strobe per channel at terminal count.
- sq  out  N_CH  square output per channel; toggles at each terminal count.
- div_q  out  N_CH*DIV_W  currently active divisor per channel, for readback.

Behaviour:
- Reset is asynchronous on rst_n low, released synchronously to clk by the surrounding reset tree. Reset values:
  - cnt[k] = 0, tick = 0, sq = 0.
  - div_q[k] = DEFAULT_DIV, truncated to DIV_W.
- Period: tick period = div_q+1 clk cycles; sq period = 2*(div_q+1) cycles.
- Per channel, each rising clk edge, in priority order:
  1. load[k]=1: div_q[k] <= div_in slice, cnt[k] <= 0, tick[k] <= 0, sq[k] holds. This applies regardless of en[k] and takes effect the next cycle.
  2. en[k]=0: cnt[k] holds, tick[k] <= 0, sq[k] holds (the channel pauses and does not restart).
  3. cnt[k]==div_q[k]: cnt[k] <= 0, tick[k] <= 1, sq[k] <= ~sq[k].
  4. Otherwise: cnt[k] <= cnt[k]+1, tick[k] <= 0.
- Latency: with en high from cnt=0, the first tick asserts on the edge after cnt reaches div_q, i.e. div_q+1 cycles after counting starts. All outputs are registered.
- div_q=0: tick stays high every cycle while en=1; sq toggles every cycle.
- div_q=max (all ones): cnt wraps to 0 via rule 3 and never overflows.
- Loading a divisor smaller than the current cnt is safe, because load clears cnt.
- Channels are fully independent; no shared state except clk/rst_n.
- Counter width is exactly DIV_W bits, compared unsigned; no saturation logic needed.

Optional Feature:
- Macro: MULTI_TICK_GEN_SYNC_EN.
- Defined:
  - Adds input port sync (1 bit, one-cycle strobe).
  - When sync=1, every channel sets cnt <= 0, tick <= 0, sq <= 0 on that edge, phase-aligning all channels.
  - sync has priority over en but not over load; a channel with load=1 in the same cycle obeys rule 1 (cnt also 0) and additionally clears sq.
- Undefined: the port is absent and no sync logic is built.

Test Plan:
- Reset: hold rst_n=0 mid-count with DIV_W=8, DEFAULT_DIV=4 -> tick=0, sq=0, div_q=4 on both channels immediately (asynchronous), without waiting for a clk edge.
- Basic divide: after reset, en=2'b11 -> tick[0] pulses exactly one cycle every 5 cycles; sq[0] toggles at each tick (period 10 cycles).
- Runtime load: load[1]=1 with div_in slice 1 = 2 while en[1]=1 -> div_q[1]=2 next cycle; first tick[1] 3 cycles after the load cycle; channel 0 period unchanged at 5.
- Enable pause: drop en[0] for 7 cycles when cnt=2 -> no tick, sq held; on re-enable, tick after 3 more cycles (cnt resumes from 2).
- Boundaries: load div=0 -> tick continuous high while en=1; load div=8'hFF -> tick period 256, cnt wraps to 0 without glitch.
- Sync (macro defined): channels at different phases, pulse sync -> both cnt=0 and sq=0 next cycle, then simultaneous ticks when divisors are equal (e.g. both 4 -> coincident ticks every 5 cycles).

Source files
------------

// File: rtl/multi_tick_gen.sv
// N_CH independent programmable tick/square generators sharing one clock.
// Optional global phase-align input `sync` is built when MULTI_TICK_GEN_SYNC_EN is defined.
module multi_tick_gen #(
   parameter int unsigned N_CH        = 2,
   parameter int unsigned DIV_W       = 25,
   parameter int unsigned DEFAULT_DIV = 19999999
) (
   input  logic                    clk,
   input  logic                    rst_n,
`ifdef MULTI_TICK_GEN_SYNC_EN
   input  logic                    sync,
`endif
   input  logic [N_CH-1:0]         en,
   input  logic [N_CH-1:0]         load,
   input  logic [N_CH*DIV_W-1:0]   div_in,
   output logic [N_CH-1:0]         tick,
   output logic [N_CH-1:0]         sq,
   output logic [N_CH*DIV_W-1:0]   div_q
);

   localparam logic [DIV_W-1:0] DivRst = DIV_W'(DEFAULT_DIV);

   logic [DIV_W-1:0] r_cnt   [N_CH];
   logic [DIV_W-1:0] w_cnt_d [N_CH];
   logic [DIV_W-1:0] r_div   [N_CH];
   logic [DIV_W-1:0] w_div_d [N_CH];
   logic [N_CH-1:0]  r_tick;
   logic [N_CH-1:0]  w_tick_d;
   logic [N_CH-1:0]  r_sq;
   logic [N_CH-1:0]  w_sq_d;
   logic             w_sync;

`ifdef MULTI_TICK_GEN_SYNC_EN
   assign w_sync = sync;
`else
   assign w_sync = 1'b0;
`endif

   // Priority per channel: load, then sync, then enable, then terminal count.
   always_comb begin
      for (int k = 0; k < int'(N_CH); k++) begin
         w_cnt_d[k]  = r_cnt[k];
         w_div_d[k]  = r_div[k];
         w_tick_d[k] = 1'b0;
         w_sq_d[k]   = r_sq[k];
         if (load[k]) begin
            w_div_d[k] = div_in[k*DIV_W +: DIV_W];
            w_cnt_d[k] = '0;
            if (w_sync) begin
               w_sq_d[k] = 1'b0;
            end
         end else if (w_sync) begin
            w_cnt_d[k] = '0;
            w_sq_d[k]  = 1'b0;
         end else if (en[k]) begin
            if (r_cnt[k] == r_div[k]) begin
               w_cnt_d[k]  = '0;
               w_tick_d[k] = 1'b1;
               w_sq_d[k]   = ~r_sq[k];
            end else begin
               w_cnt_d[k] = r_cnt[k] + DIV_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(N_CH); k++) begin
            r_cnt[k] <= '0;
            r_div[k] <= DivRst;
         end
         r_tick <= '0;
         r_sq   <= '0;
      end else begin
         for (int k = 0; k < int'(N_CH); k++) begin
            r_cnt[k] <= w_cnt_d[k];
            r_div[k] <= w_div_d[k];
         end
         r_tick <= w_tick_d;
         r_sq   <= w_sq_d;
      end
   end

   assign tick = r_tick;
   assign sq   = r_sq;

   for (genvar g = 0; g < int'(N_CH); g++) begin : g_divq
      assign div_q[g*DIV_W +: DIV_W] = r_div[g];
   end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Scoreboard bench for multi_tick_gen (N_CH=2, DIV_W=8, DEFAULT_DIV=4).
// Expected tick events are queued by the stimulus and checked by a negedge monitor.
module tb_multi_tick_gen;

   localparam int unsigned N_CH  = 2;
   localparam int unsigned DIV_W = 8;

   typedef struct {
      int          cyc;
      logic [1:0]  tick;
      logic [1:0]  sq;
      logic [15:0] divq;
   } ev_t;

   logic                  clk;
   logic                  rst_n;
   logic [N_CH-1:0]       en;
   logic [N_CH-1:0]       load;
   logic [N_CH*DIV_W-1:0] div_in;
   logic [N_CH-1:0]       tick;
   logic [N_CH-1:0]       sq;
   logic [N_CH*DIV_W-1:0] div_q;
`ifdef MULTI_TICK_GEN_SYNC_EN
   logic                  sync;
`endif

   int  cyc;
   int  checks;
   int  errors;
   ev_t exp_q[$];

   multi_tick_gen #(
      .N_CH        (N_CH),
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (4)
   ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
`ifdef MULTI_TICK_GEN_SYNC_EN
      .sync   (sync),
`endif
      .en     (en),
      .load   (load),
      .div_in (div_in),
      .tick   (tick),
      .sq     (sq),
      .div_q  (div_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int c, input logic [1:0] t, input logic [1:0] s,
                       input logic [15:0] d);
      ev_t e;
      e.cyc  = c;
      e.tick = t;
      e.sq   = s;
      e.divq = d;
      exp_q.push_back(e);
   endtask

   // Monitor: every observed tick must match the next queued event.
   always @(negedge clk) begin
      if (rst_n && tick != '0) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_tick", int'(tick), 0);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("tick_cycle", cyc, e.cyc);
            chk("tick_vec", int'(tick), int'(e.tick));
            chk("sq_vec", int'(sq), int'(e.sq));
            chk("div_q", int'(div_q), int'(e.divq));
         end
      end
   end

   initial begin
      int s, t, u, v;
      cyc    = 0;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      en     = '0;
      load   = '0;
      div_in = '0;
`ifdef MULTI_TICK_GEN_SYNC_EN
      sync   = 1'b0;
`endif
      step(2);
      #3 rst_n = 1'b1;

      // Basic divide by 5 on both channels.
      step(1);
      s = cyc;
      en = 2'b11;
      push(s + 5,  2'b11, 2'b11, {8'd4, 8'd4});
      push(s + 10, 2'b11, 2'b00, {8'd4, 8'd4});
      push(s + 15, 2'b11, 2'b11, {8'd4, 8'd4});
      step(15);

      // Runtime load of divisor 2 into channel 1 while running.
      t = cyc;
      load   = 2'b10;
      div_in = {8'd2, 8'd0};
      push(t + 4,  2'b10, 2'b01, {8'd2, 8'd4});
      push(t + 5,  2'b01, 2'b00, {8'd2, 8'd4});
      push(t + 7,  2'b10, 2'b10, {8'd2, 8'd4});
      push(t + 10, 2'b11, 2'b01, {8'd2, 8'd4});
      step(1);
      load = '0;
      step(11);

      // Asynchronous reset mid-count: outputs clear without a clock edge.
      rst_n = 1'b0;
      en    = '0;
      #1;
      chk("rst_tick", int'(tick), 0);
      chk("rst_sq", int'(sq), 0);
      chk("rst_div_q", int'(div_q), int'({8'd4, 8'd4}));
      step(2);
      #3 rst_n = 1'b1;

      // Pause channel 0 at cnt=2 for 7 cycles; it resumes from 2.
      step(1);
      u = cyc;
      en = 2'b11;
      push(u + 5,  2'b10, 2'b10, {8'd4, 8'd4});
      push(u + 10, 2'b10, 2'b00, {8'd4, 8'd4});
      push(u + 12, 2'b01, 2'b01, {8'd4, 8'd4});
      step(2);
      en = 2'b10;
      step(7);
      en = 2'b11;
      step(3);

      // Boundaries: divisor 0 on channel 0, divisor 255 on channel 1.
      v = cyc;
      load   = 2'b11;
      div_in = {8'hFF, 8'h00};
      for (int i = 2; i <= 7; i++) begin
         push(v + i, 2'b01, (i % 2 == 0) ? 2'b00 : 2'b01, {8'hFF, 8'h00});
      end
      push(v + 257, 2'b10, 2'b11, {8'hFF, 8'h00});
      push(v + 513, 2'b10, 2'b01, {8'hFF, 8'h00});
      step(1);
      load = '0;
      step(6);
      en = 2'b10;
      step(507);

`ifdef MULTI_TICK_GEN_SYNC_EN
      // Sync phase-aligns channels that started at different times.
      rst_n = 1'b0;
      en    = '0;
      step(2);
      #3 rst_n = 1'b1;
      step(1);
      s = cyc;
      en = 2'b01;
      push(s + 5,  2'b01, 2'b01, {8'd4, 8'd4});
      push(s + 12, 2'b11, 2'b11, {8'd4, 8'd4});
      push(s + 17, 2'b11, 2'b00, {8'd4, 8'd4});
      step(2);
      en = 2'b11;
      step(4);
      sync = 1'b1;
      step(1);
      sync = 1'b0;
      step(11);
`endif

      chk("events_left", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
